// File: rtl/generador_pulsos_pkg.sv
// Shared definitions for the pulse-train generator: default widths and FSM states.
package generador_pulsos_pkg;

    localparam int BITS_CANTIDAD_DEF = 8;
    localparam int BITS_ESPACIO_DEF  = 8;

    typedef enum logic [1:0] {
        REPOSO = 2'd0,
        EMITIR = 2'd1,
        ESPERA = 2'd2,
        FIN    = 2'd3
    } estado_t;

endpackage

// File: rtl/generador_pulsos_if.sv
// Pulse-counting interface: the requester (master) starts bursts, the generator (slave) emits them.
interface generador_pulsos_if
    import generador_pulsos_pkg::*;
#(
    parameter int BITS_CANTIDAD = BITS_CANTIDAD_DEF,
    parameter int BITS_ESPACIO  = BITS_ESPACIO_DEF
) ();

    logic                     iniciar;
    logic [BITS_CANTIDAD-1:0] cantidad;
    logic [BITS_ESPACIO-1:0]  espacio;
    logic                     pausar;
    logic                     pulso;
    logic                     ocupado;
    logic                     generacion_finalizada;
    logic [BITS_CANTIDAD-1:0] pulsos_emitidos;

    modport master (
        output iniciar, cantidad, espacio, pausar,
        input  pulso, ocupado, generacion_finalizada, pulsos_emitidos
    );

    modport slave (
        input  iniciar, cantidad, espacio, pausar,
        output pulso, ocupado, generacion_finalizada, pulsos_emitidos
    );

endinterface

// File: rtl/generador_pulsos_contador_espacio.sv
// Loadable down-counter timing the idle gap between pulses; flags when one cycle remains.
module contador_espacio
    import generador_pulsos_pkg::*;
#(
    parameter int BITS_ESPACIO = BITS_ESPACIO_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cargar,
    input  logic                    decrementar,
    input  logic [BITS_ESPACIO-1:0] valor,
    output logic                    es_uno
);

    logic [BITS_ESPACIO-1:0] cuenta_reg;
    logic [BITS_ESPACIO-1:0] cuenta_next;

    // Load wins over decrement; zero is a floor so the count never wraps.
    always_comb begin
        cuenta_next = cuenta_reg;
        if (cargar) begin
            cuenta_next = valor;
        end else if (decrementar && (cuenta_reg != '0)) begin
            cuenta_next = cuenta_reg - BITS_ESPACIO'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cuenta_reg <= '0;
        end else begin
            cuenta_reg <= cuenta_next;
        end
    end

    assign es_uno = (cuenta_reg == BITS_ESPACIO'(1));

endmodule

// File: rtl/generador_pulsos.sv
// Programmable pulse-train generator: emits `cantidad` single-cycle pulses separated by `espacio` idle cycles.
module generador_pulsos
    import generador_pulsos_pkg::*;
#(
    parameter int BITS_CANTIDAD = BITS_CANTIDAD_DEF,
    parameter int BITS_ESPACIO  = BITS_ESPACIO_DEF
) (
    input  logic                clk,
    input  logic                reset,
    generador_pulsos_if.slave   bus
);

    estado_t                  estado_reg, estado_next;
    logic [BITS_CANTIDAD-1:0] cantidad_reg, cantidad_next;
    logic [BITS_CANTIDAD-1:0] emitidos_reg, emitidos_next;
    logic [BITS_ESPACIO-1:0]  espacio_reg, espacio_next;
    logic                     cargar;
    logic                     decrementar;
    logic                     espera_fin;
    logic                     ocupado_reg;
    logic                     finalizada_reg;

    contador_espacio #(
        .BITS_ESPACIO (BITS_ESPACIO)
    ) u_contador_espacio (
        .clk         (clk),
        .reset       (reset),
        .cargar      (cargar),
        .decrementar (decrementar),
        .valor       (espacio_reg),
        .es_uno      (espera_fin)
    );

    always_comb begin
        estado_next   = estado_reg;
        cantidad_next = cantidad_reg;
        espacio_next  = espacio_reg;
        emitidos_next = emitidos_reg;
        cargar        = 1'b0;
        decrementar   = 1'b0;
        case (estado_reg)
            REPOSO: begin
                if (bus.iniciar) begin
                    cantidad_next = bus.cantidad;
                    espacio_next  = bus.espacio;
                    emitidos_next = '0;
                    estado_next   = (bus.cantidad == '0) ? FIN : EMITIR;
                end
            end
            EMITIR: begin
                if (!bus.pausar) begin
                    emitidos_next = emitidos_reg + BITS_CANTIDAD'(1);
                    if (emitidos_next == cantidad_reg) begin
                        estado_next = FIN;
                    end else if (espacio_reg != '0) begin
                        cargar      = 1'b1;
                        estado_next = ESPERA;
                    end
                end
            end
            ESPERA: begin
                if (!bus.pausar) begin
                    decrementar = 1'b1;
                    if (espera_fin) begin
                        estado_next = EMITIR;
                    end
                end
            end
            FIN: begin
                estado_next = REPOSO;
            end
            default: begin
                estado_next = REPOSO;
            end
        endcase
    end

    // Status flags are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            estado_reg     <= REPOSO;
            cantidad_reg   <= '0;
            espacio_reg    <= '0;
            emitidos_reg   <= '0;
            ocupado_reg    <= 1'b0;
            finalizada_reg <= 1'b0;
        end else begin
            estado_reg     <= estado_next;
            cantidad_reg   <= cantidad_next;
            espacio_reg    <= espacio_next;
            emitidos_reg   <= emitidos_next;
            ocupado_reg    <= (estado_next == EMITIR) || (estado_next == ESPERA);
            finalizada_reg <= (estado_next == FIN);
        end
    end

    assign bus.pulso                 = (estado_reg == EMITIR) & ~bus.pausar;
    assign bus.ocupado               = ocupado_reg;
    assign bus.generacion_finalizada = finalizada_reg;
    assign bus.pulsos_emitidos       = emitidos_reg;

endmodule
